rf_writeback: RTL and testbench

//  Writer side of the regfile write port (we/rd_addr/w_data). Accepts retiring

---
 rtl/rf_writeback.sv | 183 ++++++++++++++++++
 tb/tb_rf_writeback.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Regfile write-port driver: selects ALU / load / PC+4 result, waits for loads, extracts sub-words.
// Latency 1 cycle from accept (or load response) to we; wb_ready low while a load is outstanding.
module rf_writeback #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [1:0]  wb_mem_to_reg,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_pc_plus4,
    input  logic [2:0]  wb_funct3,
    input  logic [1:0]  wb_addr_lo,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        we,
    output logic [4:0]  rd_addr,
    output logic [31:0] w_data,
    output logic        err,
    output logic [31:0] instret
);

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic          err_q, err_d;
    logic [31:0]   instret_q, instret_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic          ld_rw_q, ld_rw_d;
    logic [2:0]    ld_f3_q, ld_f3_d;
    logic [1:0]    ld_lo_q, ld_lo_d;

    logic          accept;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic          ld_ok;

    assign wb_ready = (state_q == IDLE) && reset;
    assign accept   = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            w_data_q  <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
            ld_rd_q   <= '0;
            ld_rw_q   <= 1'b0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            w_data_q  <= w_data_d;
            err_q     <= err_d;
            instret_q <= instret_d;
            ld_rd_q   <= ld_rd_d;
            ld_rw_q   <= ld_rw_d;
            ld_f3_q   <= ld_f3_d;
            ld_lo_q   <= ld_lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept && wb_mem_to_reg == 2'b01) state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rsp_valid || cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sub-word extraction from the raw aligned response word
    always_comb begin
        case (ld_lo_q)
            2'd0:    ld_byte = mem_rsp_data[7:0];
            2'd1:    ld_byte = mem_rsp_data[15:8];
            2'd2:    ld_byte = mem_rsp_data[23:16];
            default: ld_byte = mem_rsp_data[31:24];
        endcase
        ld_half = ld_lo_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        ld_ok   = 1'b1;
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rsp_data;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: begin
                ld_data = '0;
                ld_ok   = 1'b0;
            end
        endcase
    end

    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        w_data_d  = w_data_q;
        err_d     = err_q;
        instret_d = instret_q;
        ld_rd_d   = ld_rd_q;
        ld_rw_d   = ld_rw_q;
        ld_f3_d   = ld_f3_q;
        ld_lo_d   = ld_lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (wb_mem_to_reg)
                        2'b00, 2'b10: begin
                            we_d      = wb_reg_write && (wb_rd != 5'd0);
                            instret_d = instret_q + 32'd1;
                            if (we_d) begin
                                rd_addr_d = wb_rd;
                                w_data_d  = wb_mem_to_reg[1] ? wb_pc_plus4 : wb_alu_result;
                            end
                        end
                        2'b01: begin
                            ld_rd_d = wb_rd;
                            ld_rw_d = wb_reg_write;
                            ld_f3_d = wb_funct3;
                            ld_lo_d = wb_addr_lo;
                        end
                        default: begin
                            err_d     = 1'b1;
                            instret_d = instret_q + 32'd1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    instret_d = instret_q + 32'd1;
                    if (ld_ok) begin
                        we_d = ld_rw_q && (ld_rd_q != 5'd0);
                        if (we_d) begin
                            rd_addr_d = ld_rd_q;
                            w_data_d  = ld_data;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    // Abandoned load: flag it but do not count it as retired
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign we      = we_q;
    assign rd_addr = rd_addr_q;
    assign w_data  = w_data_q;
    assign err     = err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: expected writes queued at stimulus time, compared as we pulses appear.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_mem_to_reg;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_pc_plus4;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] w_data;
    logic        err;
    logic [31:0] instret;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_instret = 32'd0;

    always #5 clk = ~clk;

    rf_writeback #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_alu_result (wb_alu_result),
        .wb_pc_plus4   (wb_pc_plus4),
        .wb_funct3     (wb_funct3),
        .wb_addr_lo    (wb_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .we            (we),
        .rd_addr       (rd_addr),
        .w_data        (w_data),
        .err           (err),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard: every we pulse must match the oldest queued write
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_rd", {27'd0, rd_addr}, {27'd0, e.rd});
                check("wr_data", w_data, e.dat);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] m2r,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3, input logic [1:0] lo);
        wb_valid      = 1'b1;
        wb_reg_write  = rw;
        wb_rd         = rd;
        wb_mem_to_reg = m2r;
        wb_alu_result = alu;
        wb_pc_plus4   = pc;
        wb_funct3     = f3;
        wb_addr_lo    = lo;
        tick(1);
        wb_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic alu_op(input logic rw, input logic [4:0] rd, input logic [1:0] m2r,
                          input logic [31:0] val);
        if (rw && rd != 5'd0) exp_q.push_back('{rd, val});
        exp_instret++;
        if (m2r == 2'b10) issue(rw, rd, m2r, 32'hDEAD_0000, val, 3'd0, 2'd0);
        else              issue(rw, rd, m2r, val, 32'hDEAD_0004, 3'd0, 2'd0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] data, input int wait_cyc,
                        input logic exp_wr, input logic [31:0] exp_dat);
        issue(1'b1, rd, 2'b01, 32'h0BAD_0BAD, 32'h0, f3, lo);
        check("ld_ready_wait", {31'd0, wb_ready}, 32'd0);
        for (int i = 1; i < wait_cyc; i++) begin
            tick(1);
            check("ld_ready_wait", {31'd0, wb_ready}, 32'd0);
        end
        if (exp_wr) exp_q.push_back('{rd, exp_dat});
        exp_instret++;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick(1);
        mem_rsp_valid = 1'b0;
        check("ld_instret", instret, exp_instret);
        check("ld_ready_back", {31'd0, wb_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_mem_to_reg = '0;
        wb_alu_result = '0; wb_pc_plus4 = '0; wb_funct3 = '0; wb_addr_lo = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(3);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_ready", {31'd0, wb_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, wb_ready}, 32'd1);

        alu_op(1'b1, 5'd5, 2'b00, 32'h1234_5678);
        check("alu_instret", instret, 32'd1);
        alu_op(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF);
        check("x0_instret", instret, 32'd2);
        check("x0_hold_rd", {27'd0, rd_addr}, 32'd5);
        check("x0_hold_data", w_data, 32'h1234_5678);
        alu_op(1'b1, 5'd1, 2'b10, 32'h0000_0104);

        // Back-to-back accepts, including one that does not write
        alu_op(1'b1, 5'd10, 2'b00, 32'hAAAA_0001);
        alu_op(1'b1, 5'd11, 2'b00, 32'hAAAA_0002);
        alu_op(1'b0, 5'd12, 2'b00, 32'hAAAA_0003);
        alu_op(1'b1, 5'd31, 2'b10, 32'hAAAA_0004);
        check("b2b_instret", instret, exp_instret);

        // Response in the accept cycle itself must be ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        load(5'd7, 3'b000, 2'd3, 32'h80FF_0000, 3, 1'b1, 32'hFFFF_FF80);
        load(5'd8, 3'b101, 2'd2, 32'hBEEF_1234, 1, 1'b1, 32'h0000_BEEF);
        load(5'd8, 3'b001, 2'd1, 32'h1234_8001, 2, 1'b1, 32'hFFFF_8001);
        load(5'd9, 3'b100, 2'd1, 32'h0000_AB00, 1, 1'b1, 32'h0000_00AB);
        load(5'd10, 3'b010, 2'd2, 32'hCAFE_F00D, 4, 1'b1, 32'hCAFE_F00D);
        load(5'd3, 3'b000, 2'd2, 32'h007F_0000, 1, 1'b1, 32'h0000_007F);
        check("loads_err", {31'd0, err}, 32'd0);

        // Response while idle is ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_5555;
        tick(1);
        mem_rsp_valid = 1'b0;
        tick(1);
        check("idle_rsp_instret", instret, exp_instret);

        // Load timeout: 16 cycles in WAIT_MEM
        issue(1'b1, 5'd6, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            check("tmo_ready_low", {31'd0, wb_ready}, 32'd0);
        end
        check("tmo_err_early", {31'd0, err}, 32'd0);
        tick(1);
        check("tmo_ready_back", {31'd0, wb_ready}, 32'd1);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_instret", instret, exp_instret);
        alu_op(1'b1, 5'd2, 2'b00, 32'h0000_BEEF);
        check("post_tmo_err_sticky", {31'd0, err}, 32'd1);

        // Reset while waiting for a load drops it
        issue(1'b1, 5'd9, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("rst_wait_ready", {31'd0, wb_ready}, 32'd0);
        reset = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        tick(1);
        mem_rsp_valid = 1'b0;
        exp_instret = 32'd0;
        check("rst_wait_we", {31'd0, we}, 32'd0);
        check("rst_wait_instret", instret, 32'd0);
        check("rst_wait_err", {31'd0, err}, 32'd0);
        check("rst_wait_idle", {31'd0, wb_ready}, 32'd1);

        // Illegal funct3 on a load: error, no write, still retires
        load(5'd4, 3'b011, 2'd0, 32'h1234_5678, 2, 1'b0, 32'h0);
        check("badf3_err", {31'd0, err}, 32'd1);
        load(5'd0, 3'b010, 2'd0, 32'h1234_5678, 1, 1'b0, 32'h0);

        // Illegal mem_to_reg after a reset clears err
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_instret = 32'd0;
        alu_op(1'b1, 5'd13, 2'b11, 32'h0);
        exp_q.delete();
        check("m2r11_err", {31'd0, err}, 32'd1);
        check("m2r11_instret", instret, 32'd1);
        tick(3);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
